// File: rtl/snake_sprite_row_fetch_if.sv
// -----------------------------------------------------------------------------
// snake_sprite_row_fetch_if
// Read-only bus between a sprite row fetcher and a 16x16 sprite ROM
// (256 x 16-bit words, address = {row[3:0], col[3:0]}, 1-cycle read latency).
//   rom_address     fetcher -> ROM   8-bit word address
//   rom_chipselect  fetcher -> ROM   access strobe
//   rom_clken       fetcher -> ROM   ROM clock enable (driven with chipselect)
//   rom_readdata    ROM -> fetcher   word valid the cycle after the address
// Modports: master = fetcher side, slave = ROM side.
// -----------------------------------------------------------------------------
interface snake_sprite_row_fetch_if;
    logic [7:0]  rom_address;
    logic        rom_chipselect;
    logic        rom_clken;
    logic [15:0] rom_readdata;

    modport master (
        output rom_address,
        output rom_chipselect,
        output rom_clken,
        input  rom_readdata
    );

    modport slave (
        input  rom_address,
        input  rom_chipselect,
        input  rom_clken,
        output rom_readdata
    );
endinterface

// File: rtl/snake_sprite_row_fetch.sv
// -----------------------------------------------------------------------------
// snake_sprite_row_fetch
// Prefetches one 16-pixel row of a sprite per scanline into the back half of a
// double-buffered line buffer, then streams the front half to the compositor as
// colour-keyed RGB565 pixels against hcount.
//
// Optional feature macro: SPRITE_FLIP_EN
//   defined   -> adds i_flip_h; when set at line_start the row is fetched
//                mirrored (back[k] = ROM[{row, 15-k}]).
//   undefined -> no i_flip_h port, columns always fetched 0..15.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   i_enable          layer enable; low aborts fetch, clears buffers' valid flags
//   i_line_start      1-cycle pulse at start of horizontal blank
//   i_sprite_row      row to fetch for the next line (sampled at line_start)
//   i_x_origin        sprite left edge for the next line (sampled at line_start)
//   i_hcount          current pixel x
//   i_flip_h          (SPRITE_FLIP_EN only) mirror the next line
//   rom               ROM bus, master modport
//   o_pix_valid       opaque sprite pixel at this hcount (1 cycle late)
//   o_pix_rgb         pixel colour, 0 when o_pix_valid=0
//   o_overrun         sticky: line_start arrived before the previous fetch ended
// -----------------------------------------------------------------------------
module snake_sprite_row_fetch #(
    parameter int          XW        = 11,
    parameter logic [15:0] KEY_COLOR = 16'hF81F
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_enable,
    input  logic          i_line_start,
    input  logic [3:0]    i_sprite_row,
    input  logic [XW-1:0] i_x_origin,
    input  logic [XW-1:0] i_hcount,
`ifdef SPRITE_FLIP_EN
    input  logic          i_flip_h,
`endif
    snake_sprite_row_fetch_if.master rom,
    output logic          o_pix_valid,
    output logic [15:0]   o_pix_rgb,
    output logic          o_overrun
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_READY = 2'd3
    } state_t;

    state_t        r_state;
    logic [3:0]    r_col;          // buffer slot of the address currently driven
    logic [3:0]    r_row;
    logic          r_flip;
    logic [XW-1:0] r_org_back;
    logic [XW-1:0] r_org_front;
    logic          r_front_vld;
    logic          r_back_vld;
    logic          r_sel;          // buffer half currently displayed
    logic          r_cap_vld_p1;   // ROM word for slot r_cap_col_p1 arrives this cycle
    logic [3:0]    r_cap_col_p1;
    logic [15:0]   r_buf [0:31];   // {half, slot}

    logic          w_flip;
    logic [3:0]    w_next_col;
    logic [XW-1:0] w_idx;
    logic          w_in_win;
    logic [15:0]   w_front_word;
    logic          w_pix_hit;

`ifdef SPRITE_FLIP_EN
    assign w_flip = i_flip_h;
`else
    assign w_flip = 1'b0;
`endif

    // Mirroring is just the slot index with all bits inverted (15-k).
    assign w_next_col = (r_col + 4'd1) ^ {4{r_flip}};

    // ---- fetch control: address issue, capture tracking, buffer swap ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state            <= S_IDLE;
            rom.rom_address    <= 8'd0;
            rom.rom_chipselect <= 1'b0;
            rom.rom_clken      <= 1'b0;
            o_overrun          <= 1'b0;
            r_front_vld        <= 1'b0;
            r_back_vld         <= 1'b0;
            r_sel              <= 1'b0;
            r_col              <= 4'd0;
            r_cap_vld_p1       <= 1'b0;
        end else begin
            // A capture is only armed by a FETCH cycle that is not restarted,
            // so a restart drops the in-flight word of the abandoned fetch.
            r_cap_vld_p1 <= 1'b0;
            if (!i_enable) begin
                r_state            <= S_IDLE;
                rom.rom_chipselect <= 1'b0;
                rom.rom_clken      <= 1'b0;
                r_front_vld        <= 1'b0;
                r_back_vld         <= 1'b0;
            end else if (i_line_start) begin
                if (r_state == S_FETCH || r_state == S_DRAIN) begin
                    o_overrun   <= 1'b1;
                    r_front_vld <= 1'b0;
                end else begin
                    r_sel       <= ~r_sel;
                    r_front_vld <= r_back_vld;
                    r_org_front <= r_org_back;
                end
                r_back_vld         <= 1'b0;
                r_row              <= i_sprite_row;
                r_flip             <= w_flip;
                r_org_back         <= i_x_origin;
                r_col              <= 4'd0;
                rom.rom_address    <= {i_sprite_row, {4{w_flip}}};
                rom.rom_chipselect <= 1'b1;
                rom.rom_clken      <= 1'b1;
                r_state            <= S_FETCH;
            end else begin
                case (r_state)
                    S_FETCH: begin
                        r_cap_vld_p1 <= 1'b1;
                        r_cap_col_p1 <= r_col;
                        if (r_col == 4'd15) begin
                            rom.rom_chipselect <= 1'b0;
                            rom.rom_clken      <= 1'b0;
                            r_state            <= S_DRAIN;
                        end else begin
                            r_col           <= r_col + 4'd1;
                            rom.rom_address <= {r_row, w_next_col};
                        end
                    end
                    S_DRAIN: begin
                        // The last slot is written on this edge.
                        if (r_cap_vld_p1) begin
                            r_back_vld <= 1'b1;
                            r_state    <= S_READY;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---- capture: ROM word lands in the back half ----
    always_ff @(posedge clk) begin
        if (r_cap_vld_p1) begin
            r_buf[{~r_sel, r_cap_col_p1}] <= rom.rom_readdata;
        end
    end

    // Window test without wrap: an origin near the top of the range clips.
    assign w_idx        = i_hcount - r_org_front;
    assign w_in_win     = (i_hcount >= r_org_front) && (w_idx < XW'(16));
    assign w_front_word = r_buf[{r_sel, w_idx[3:0]}];
    assign w_pix_hit    = i_enable && r_front_vld && w_in_win && (w_front_word != KEY_COLOR);

    // ---- pixel output stage ----
    always_ff @(posedge clk) begin
        if (reset) begin
            o_pix_valid <= 1'b0;
            o_pix_rgb   <= 16'd0;
        end else begin
            o_pix_valid <= w_pix_hit;
            o_pix_rgb   <= w_pix_hit ? w_front_word : 16'd0;
        end
    end

endmodule

// File: tb/tb_snake_sprite_row_fetch.sv
// -----------------------------------------------------------------------------
// tb_snake_sprite_row_fetch
// Self-checking bench: directed scanline scenarios followed by randomized lines
// ($urandom rows, origins, ROM contents and line_start spacing), compared each
// cycle against a line-level reference model (snapshots of whole sprite rows,
// a countdown for the fetch window, front/back copies swapped per scanline).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_snake_sprite_row_fetch;

    localparam int          XW  = 11;
    localparam logic [15:0] KEY = 16'hF81F;
`ifdef SPRITE_FLIP_EN
    localparam bit FLIP_ON = 1'b1;
`else
    localparam bit FLIP_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          i_enable;
    logic          i_line_start;
    logic [3:0]    i_sprite_row;
    logic [XW-1:0] i_x_origin;
    logic [XW-1:0] i_hcount;
    logic          tb_flip_req;
    logic          o_pix_valid;
    logic [15:0]   o_pix_rgb;
    logic          o_overrun;

    snake_sprite_row_fetch_if rom_if();

    snake_sprite_row_fetch #(.XW(XW), .KEY_COLOR(KEY)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_enable     (i_enable),
        .i_line_start (i_line_start),
        .i_sprite_row (i_sprite_row),
        .i_x_origin   (i_x_origin),
        .i_hcount     (i_hcount),
`ifdef SPRITE_FLIP_EN
        .i_flip_h     (tb_flip_req),
`endif
        .rom          (rom_if),
        .o_pix_valid  (o_pix_valid),
        .o_pix_rgb    (o_pix_rgb),
        .o_overrun    (o_overrun)
    );

    always #5 clk = ~clk;

    // Sprite ROM: registered read, 1-cycle latency.
    logic [15:0] rom_mem [256];
    always @(posedge clk) begin
        if (rom_if.rom_chipselect && rom_if.rom_clken)
            rom_if.rom_readdata <= rom_mem[rom_if.rom_address];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] m_back_pix  [16];
    logic [15:0] m_front_pix [16];
    int          m_back_org, m_front_org;
    bit          m_back_ok, m_front_ok, m_ovr, m_flip;
    int          m_row;
    int          m_left;          // edges until the fetched row is complete
    bit          e_pv, e_cs, e_addr_chk;
    logic [15:0] e_rgb;
    logic [7:0]  e_addr;
    bit          chk_on = 1'b0;

    always begin
        int idx, k, col;
        @(posedge clk);
        if (reset) begin
            m_left = 0; m_front_ok = 0; m_back_ok = 0; m_ovr = 0;
            e_pv = 0; e_rgb = 0; e_cs = 0; e_addr = 0; e_addr_chk = 1;
        end else begin
            idx   = int'(i_hcount) - m_front_org;
            e_pv  = 0;
            e_rgb = 0;
            if (i_enable && m_front_ok && idx >= 0 && idx < 16 && m_front_pix[idx] != KEY) begin
                e_pv  = 1;
                e_rgb = m_front_pix[idx];
            end
            if (!i_enable) begin
                m_left = 0; m_front_ok = 0; m_back_ok = 0;
            end else if (i_line_start) begin
                if (m_left > 0) begin
                    m_ovr = 1; m_front_ok = 0;
                end else begin
                    m_front_ok  = m_back_ok;
                    m_front_pix = m_back_pix;
                    m_front_org = m_back_org;
                end
                m_back_ok  = 0;
                m_row      = int'(i_sprite_row);
                m_flip     = tb_flip_req & FLIP_ON;
                m_back_org = int'(i_x_origin);
                for (int j = 0; j < 16; j++)
                    m_back_pix[j] = rom_mem[m_row * 16 + (m_flip ? 15 - j : j)];
                m_left = 17;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_back_ok = 1;
            end
            e_cs       = (m_left >= 2);
            e_addr_chk = e_cs;
            if (e_cs) begin
                k      = 17 - m_left;
                col    = m_flip ? 15 - k : k;
                e_addr = 8'(m_row * 16 + col);
            end
        end
        #1;
        if (chk_on) begin
            chk("pix_valid", {31'd0, o_pix_valid}, {31'd0, e_pv});
            chk("pix_rgb", {16'd0, o_pix_rgb}, {16'd0, e_rgb});
            chk("overrun", {31'd0, o_overrun}, {31'd0, m_ovr});
            chk("chipselect", {31'd0, rom_if.rom_chipselect}, {31'd0, e_cs});
            chk("clken", {31'd0, rom_if.rom_clken}, {31'd0, e_cs});
            if (e_addr_chk)
                chk("rom_address", {24'd0, rom_if.rom_address}, {24'd0, e_addr});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic line(input int row, input int org, input bit flip);
        i_line_start = 1'b1;
        i_sprite_row = 4'(row);
        i_x_origin   = XW'(org);
        tb_flip_req  = flip;
        @(posedge clk); #1;
        i_line_start = 1'b0;
    endtask

    task automatic sweep(input int h0, input int n);
        for (int i = 0; i < n; i++) begin
            i_hcount = XW'((h0 + i) % 2048);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1; i_enable = 1'b0; i_line_start = 1'b0; i_sprite_row = 4'd0;
        i_x_origin = '0; i_hcount = '0; tb_flip_req = 1'b0;
        for (int a = 0; a < 256; a++) rom_mem[a] = 16'(a);
        rom_mem[8'h35] = KEY;
        cycles(3);
        chk_on = 1'b1;
        chk("rst_pix_valid", {31'd0, o_pix_valid}, 32'd0);
        chk("rst_pix_rgb", {16'd0, o_pix_rgb}, 32'd0);
        chk("rst_overrun", {31'd0, o_overrun}, 32'd0);
        chk("rst_cs", {31'd0, rom_if.rom_chipselect}, 32'd0);
        chk("rst_clken", {31'd0, rom_if.rom_clken}, 32'd0);
        chk("rst_addr", {24'd0, rom_if.rom_address}, 32'd0);
        reset = 1'b0;
        i_enable = 1'b1;
        cycles(2);

        // Row 3 at x=100: address sequence and strobe window.
        line(3, 100, 1'b0);
        chk("addr_T1", {24'd0, rom_if.rom_address}, 32'h30);
        chk("cs_T1", {31'd0, rom_if.rom_chipselect}, 32'd1);
        cycles(15);
        chk("addr_T16", {24'd0, rom_if.rom_address}, 32'h3F);
        cycles(1);
        chk("cs_T17", {31'd0, rom_if.rom_chipselect}, 32'd0);
        cycles(2);

        // Swap and sweep 95..120, with a keyed pixel at 105.
        line(7, 100, 1'b0);
        for (int h = 95; h <= 120; h++) begin
            i_hcount = XW'(h);
            @(posedge clk); #1;
            if (h == 100) chk("px100", {16'd0, o_pix_rgb}, 32'h30);
            if (h == 105) chk("px105_key", {31'd0, o_pix_valid}, 32'd0);
            if (h == 106) chk("px106", {16'd0, o_pix_rgb}, 32'h36);
            if (h == 115) chk("px115", {16'd0, o_pix_rgb}, 32'h3F);
            if (h == 116) chk("px116_out", {31'd0, o_pix_valid}, 32'd0);
        end
        cycles(2);

        // Overrun: second line_start at T+8 of a fetch.
        line(5, 300, 1'b0);
        cycles(7);
        line(6, 300, 1'b0);
        chk("overrun_set", {31'd0, o_overrun}, 32'd1);
        sweep(295, 26);
        line(1, 300, 1'b0);
        sweep(295, 26);

        // Origin near the top of the range clips, never wraps.
        line(9, 2040, 1'b0);
        cycles(20);
        line(9, 2040, 1'b0);
        for (int i = 0; i < 24; i++) begin
            i_hcount = XW'((2036 + i) % 2048);
            @(posedge clk); #1;
            if (i == 11) chk("px2047", {16'd0, o_pix_rgb}, 32'h97);
            if (i == 12) chk("px0_clip", {31'd0, o_pix_valid}, 32'd0);
        end
        cycles(2);

        // Enable drop mid-fetch, ignored line_start while disabled, recovery.
        line(4, 50, 1'b1);
        cycles(5);
        i_enable = 1'b0;
        cycles(1);
        chk("abort_cs", {31'd0, rom_if.rom_chipselect}, 32'd0);
        line(2, 50, 1'b1);
        cycles(3);
        i_enable = 1'b1;
        line(2, 50, 1'b1);
        sweep(46, 24);
        line(2, 50, 1'b1);
        sweep(46, 24);

        // Randomized scanlines.
        for (int a = 0; a < 256; a++)
            rom_mem[a] = ($urandom_range(0, 7) == 0) ? KEY : 16'($urandom);
        for (int it = 0; it < 40; it++) begin
            int org, row;
            for (int j = 0; j < 4; j++)
                rom_mem[$urandom_range(0, 255)] = ($urandom_range(0, 3) == 0) ? KEY : 16'($urandom);
            row = int'($urandom_range(0, 15));
            org = ($urandom_range(0, 1) == 0) ? int'($urandom_range(2030, 2047))
                                               : int'($urandom_range(0, 2047));
            line(row, org, 1'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                cycles(int'($urandom_range(0, 15)));
                line(row ^ 1, org, 1'($urandom));
            end
            cycles(int'($urandom_range(18, 22)));
            line(int'($urandom_range(0, 15)), int'($urandom_range(0, 2047)), 1'($urandom));
            sweep(org + 2044, 24);
        end

        cycles(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
